// File: rtl/muldiv_sequencer.sv
// Iterative DATA_WIDTH multiply/divide sequencer: shift-add MUL, restoring DIV, one step per clock.
// Optional two's-complement ops are enabled by defining MULDIV_SIGNED_EN.
module muldiv_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  flush,
    output logic                  stall_pipe,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic [DATA_WIDTH-1:0] result_lo,
    output logic                  div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0]  ZERO_W   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]  ONES_W   = {DATA_WIDTH{1'b1}};

    state_t                  state_r;
    logic [COUNT_WIDTH-1:0]  cnt_r;
    logic [DATA_WIDTH-1:0]   acc_r;
    logic [DATA_WIDTH-1:0]   lo_r;
    logic [DATA_WIDTH-1:0]   opnd_r;
    logic                    is_div_r;
    logic                    busy_r;
    logic                    done_r;
    logic [DATA_WIDTH-1:0]   result_hi_r;
    logic [DATA_WIDTH-1:0]   result_lo_r;
    logic                    div_by_zero_r;

    logic                    idle_or_done_s;
    logic                    accept_s;
    logic                    dz_s;
    logic [DATA_WIDTH-1:0]   mag_a_s;
    logic [DATA_WIDTH-1:0]   mag_b_s;
    logic [DATA_WIDTH:0]     mul_sum_s;
    logic [DATA_WIDTH:0]     div_shift_s;
    logic [DATA_WIDTH:0]     div_diff_s;
    logic [DATA_WIDTH-1:0]   acc_nx_s;
    logic [DATA_WIDTH-1:0]   lo_nx_s;
    logic [DATA_WIDTH-1:0]   res_hi_s;
    logic [DATA_WIDTH-1:0]   res_lo_s;

    function automatic logic [DATA_WIDTH-1:0] negate_w(input logic [DATA_WIDTH-1:0] x);
        return ~x + DATA_WIDTH'(1);
    endfunction

    // Accept decode; stall is combinational so decode holds the instruction on the accepting cycle.
    always_comb begin
        idle_or_done_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
        accept_s       = start & ~flush & idle_or_done_s;
        dz_s           = op[0] & (operand_b == ZERO_W);
        stall_pipe     = accept_s | (state_r == ST_RUN);
    end

`ifdef MULDIV_SIGNED_EN
    logic sign_a_s;
    logic sign_b_s;
    logic neg_q_r;
    logic neg_r_r;

    // Signed ops run the unsigned core on magnitudes.
    always_comb begin
        sign_a_s = op[1] & operand_a[DATA_WIDTH-1];
        sign_b_s = op[1] & operand_b[DATA_WIDTH-1];
        if (sign_a_s) begin
            mag_a_s = negate_w(operand_a);
        end else begin
            mag_a_s = operand_a;
        end
        if (sign_b_s) begin
            mag_b_s = negate_w(operand_b);
        end else begin
            mag_b_s = operand_b;
        end
    end

    // Sign fix-up: product/quotient take sign_a^sign_b, remainder follows the dividend.
    always_comb begin
        res_hi_s = acc_nx_s;
        res_lo_s = lo_nx_s;
        if (is_div_r) begin
            if (neg_r_r) begin
                res_hi_s = negate_w(acc_nx_s);
            end else begin
                res_hi_s = acc_nx_s;
            end
            if (neg_q_r) begin
                res_lo_s = negate_w(lo_nx_s);
            end else begin
                res_lo_s = lo_nx_s;
            end
        end else if (neg_q_r) begin
            {res_hi_s, res_lo_s} = ~{acc_nx_s, lo_nx_s} + (2 * DATA_WIDTH)'(1);
        end else begin
            {res_hi_s, res_lo_s} = {acc_nx_s, lo_nx_s};
        end
    end

    // Result sign bookkeeping, captured on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (accept_s) begin
            neg_q_r <= sign_a_s ^ sign_b_s;
            neg_r_r <= sign_a_s;
        end else begin
            neg_q_r <= neg_q_r;
            neg_r_r <= neg_r_r;
        end
    end
`else
    logic unused_op_s;

    // op[1] has no meaning in the unsigned-only build.
    always_comb begin
        unused_op_s = op[1];
        mag_a_s     = operand_a;
        mag_b_s     = operand_b;
        res_hi_s    = acc_nx_s;
        res_lo_s    = lo_nx_s;
    end
`endif

    // One datapath step: shift-add for MUL ({acc,lo} shifts right), restoring subtract for DIV.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r} + (lo_r[0] ? {1'b0, opnd_r} : {(DATA_WIDTH + 1){1'b0}});
        div_shift_s = {acc_r, lo_r[DATA_WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (is_div_r) begin
            if (div_shift_s >= {1'b0, opnd_r}) begin
                acc_nx_s = div_diff_s[DATA_WIDTH-1:0];
                lo_nx_s  = {lo_r[DATA_WIDTH-2:0], 1'b1};
            end else begin
                acc_nx_s = div_shift_s[DATA_WIDTH-1:0];
                lo_nx_s  = {lo_r[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nx_s = mul_sum_s[DATA_WIDTH:1];
            lo_nx_s  = {mul_sum_s[0], lo_r[DATA_WIDTH-1:1]};
        end
    end

    // Control FSM with iteration counter, operand latches and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {COUNT_WIDTH{1'b0}};
            acc_r         <= ZERO_W;
            lo_r          <= ZERO_W;
            opnd_r        <= ZERO_W;
            is_div_r      <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            result_hi_r   <= ZERO_W;
            result_lo_r   <= ZERO_W;
            div_by_zero_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        cnt_r         <= {COUNT_WIDTH{1'b0}};
                        acc_r         <= ZERO_W;
                        is_div_r      <= op[0];
                        div_by_zero_r <= dz_s;
                        if (dz_s) begin
                            state_r     <= ST_DONE;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            result_hi_r <= operand_a;
                            result_lo_r <= ONES_W;
                        end else begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                            // MUL keeps the multiplier in lo_r; DIV keeps the dividend there.
                            lo_r    <= op[0] ? mag_a_s : mag_b_s;
                            opnd_r  <= op[0] ? mag_b_s : mag_a_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else if (cnt_r == LAST_CNT) begin
                        state_r     <= ST_DONE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        acc_r       <= acc_nx_s;
                        lo_r        <= lo_nx_s;
                        result_hi_r <= res_hi_s;
                        result_lo_r <= res_lo_s;
                    end else begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        cnt_r   <= cnt_r + COUNT_WIDTH'(1);
                        acc_r   <= acc_nx_s;
                        lo_r    <= lo_nx_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign result_hi   = result_hi_r;
    assign result_lo   = result_lo_r;
    assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer; expected signed results follow MULDIV_SIGNED_EN.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] operand_a = 16'h0000;
    logic [15:0] operand_b = 16'h0000;
    logic        flush = 1'b0;
    logic        stall_pipe;
    logic        busy;
    logic        done;
    logic [15:0] result_hi;
    logic [15:0] result_lo;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dz;
        int          at;
        string       name;
    } exp_t;

    exp_t sb[$];

    muldiv_sequencer #(.DATA_WIDTH(16), .COUNT_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .stall_pipe(stall_pipe), .busy(busy), .done(done),
        .result_hi(result_hi), .result_lo(result_lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_hi"}, {16'h0, result_hi}, {16'h0, e.hi});
                chk({e.name, "_lo"}, {16'h0, result_lo}, {16'h0, e.lo});
                chk({e.name, "_dz"}, {31'h0, div_by_zero}, {31'h0, e.dz});
                chk({e.name, "_cycle"}, cyc, e.at);
            end
        end
    end

    task automatic push(input logic [15:0] eh, input logic [15:0] el, input logic edz,
                        input int at, input string nm);
        exp_t e;
        e.hi = eh; e.lo = el; e.dz = edz; e.at = at; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got %0d pending results, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase with the unit idle.
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eh, input logic [15:0] el, input logic edz,
                          input string nm);
        int lat;
        lat = (o[0] && b == 16'h0) ? 0 : 16;
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        push(eh, el, edz, cyc + 1 + lat, nm);
        #1;
        chk({nm, "_stall_accept"}, {31'h0, stall_pipe}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        if (lat == 16) chk({nm, "_busy_run"}, {31'h0, busy}, 32'd1);
        drain(40);
        chk({nm, "_busy_after"}, {31'h0, busy}, 32'd0);
    endtask

    initial begin
        int c0;
        #12;
        chk("reset_busy", {31'h0, busy}, 32'd0);
        chk("reset_done", {31'h0, done}, 32'd0);
        chk("reset_stall", {31'h0, stall_pipe}, 32'd0);
        chk("reset_res", {result_hi, result_lo}, 32'h0);
        chk("reset_dz", {31'h0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b00, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, "mul_1234x10");
        run_op(2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, "mul_ffffxffff");
        run_op(2'b01, 16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0, "div_100_7");
        run_op(2'b01, 16'h0005, 16'h0009, 16'h0005, 16'h0000, 1'b0, "div_5_9");
        run_op(2'b01, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, "div_ffff_1");
        run_op(2'b01, 16'h00AB, 16'h0000, 16'h00AB, 16'hFFFF, 1'b1, "div_by_zero");
        run_op(2'b00, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0, "mul_dz_clear");

        // Back-to-back MULs with start held through RUN and DONE.
        c0 = cyc;
        op = 2'b00; operand_a = 16'h0100; operand_b = 16'h0100; start = 1'b1;
        push(16'h0001, 16'h0000, 1'b0, c0 + 17, "b2b_first");
        push(16'h0000, 16'h01FE, 1'b0, c0 + 34, "b2b_second");
        @(posedge clk); #1;
        operand_a = 16'h00FF; operand_b = 16'h0002;
        repeat (16) @(posedge clk);
        #1;
        chk("b2b_stall_in_done", {31'h0, stall_pipe}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy_second", {31'h0, busy}, 32'd1);
        drain(40);

        // Flush a DIV at iteration 5: no done, results held.
        op = 2'b01; operand_a = 16'h1000; operand_b = 16'h0003; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {31'h0, busy}, 32'd0);
        chk("flush_stall", {31'h0, stall_pipe}, 32'd0);
        chk("flush_results", {result_hi, result_lo}, 32'h0000_01FE);
        chk("flush_dz", {31'h0, div_by_zero}, 32'd0);
        repeat (20) @(posedge clk);
        #1;

        // Flush wins over start in IDLE.
        op = 2'b00; operand_a = 16'h0002; operand_b = 16'h0002; start = 1'b1; flush = 1'b1;
        #1;
        chk("flush_start_stall", {31'h0, stall_pipe}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'h0, busy}, 32'd0);

        // Asynchronous reset at iteration 8 of a MUL.
        op = 2'b00; operand_a = 16'h1111; operand_b = 16'h0002; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_stall", {31'h0, stall_pipe}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_results", {result_hi, result_lo}, 32'h0);
        chk("rst_dz", {31'h0, div_by_zero}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef MULDIV_SIGNED_EN
        run_op(2'b10, 16'hFFFA, 16'h0003, 16'hFFFF, 16'hFFEE, 1'b0, "smul_m6x3");
        run_op(2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, "sdiv_m7_2");
        run_op(2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, "sdiv_ovf");
        run_op(2'b11, 16'hFFF0, 16'h0000, 16'hFFF0, 16'hFFFF, 1'b1, "sdiv_by_zero");
`else
        run_op(2'b10, 16'hFFFA, 16'h0003, 16'h0002, 16'hFFEE, 1'b0, "umul_op1_fffax3");
        run_op(2'b11, 16'hFFF9, 16'h0002, 16'h0001, 16'h7FFC, 1'b0, "udiv_op1_fff9_2");
        run_op(2'b11, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, "udiv_op1_8000_ffff");
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
